rtc_alarm_ctrl: RTL

//   Sits downstream of the DS1302 reader, which supplies BCD hour, minute and second.

---
 rtl/rtc_alarm_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_alarm_ctrl.sv
// Alarm controller for a BCD real-time clock: edits and stores an HH:MM alarm and gates the buzzer while ringing.
// Optional snooze on acknowledge is compiled in with `define ALARM_SNOOZE_EN.
module rtc_alarm_ctrl #(
  parameter int BEEP_CYCLES  = 12_500_000,
  parameter int RING_SECONDS = 60
`ifdef ALARM_SNOOZE_EN
  , parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] time_hour,
  input  logic [7:0] time_min,
  input  logic [7:0] time_sec,
  input  logic       key_set,
  input  logic       key_inc,
  input  logic       key_ack,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic [1:0] edit_field,
  output logic       armed,
  output logic       ringing,
  output logic       buzz_req
);

  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
  localparam logic [7:0]    RING_LAST = 8'(RING_SECONDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EDIT_H = 2'd1, EDIT_M = 2'd2, RINGING = 2'd3} state_t;

  state_t          state, state_nx;
  logic [7:0]      prev_sec;
  logic [7:0]      alarm_hour_nx, alarm_min_nx;
  logic            armed_nx, buzz_nx;
  logic [BW-1:0]   beep_cnt, beep_cnt_nx;
  logic [7:0]      ring_cnt, ring_cnt_nx;
  logic            sec_tick, alarm_hit, trigger;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sec_tick  = (time_sec != prev_sec);
  assign alarm_hit = sec_tick & armed & (time_sec == 8'h00) &
                     (time_hour == alarm_hour) & (time_min == alarm_min);

`ifdef ALARM_SNOOZE_EN
  logic       snooze_pending, snooze_pending_nx;
  logic [7:0] snooze_hour, snooze_hour_nx, snooze_min, snooze_min_nx;
  logic [7:0] min_sum, hour_bin, snz_min_bin, snz_hour_bin;
  logic [7:0] snz_hour_calc, snz_min_calc;
  logic       snooze_hit;

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  // Snooze target: current RTC HH:MM plus SNOOZE_MIN, carrying minutes into the hour.
  always_comb begin
    min_sum  = bcd_to_bin(time_min) + 8'(SNOOZE_MIN);
    hour_bin = bcd_to_bin(time_hour);
    if (min_sum >= 8'd60) begin
      snz_min_bin  = min_sum - 8'd60;
      snz_hour_bin = (hour_bin == 8'd23) ? 8'd0 : hour_bin + 8'd1;
    end else begin
      snz_min_bin  = min_sum;
      snz_hour_bin = hour_bin;
    end
    snz_hour_calc = bin_to_bcd(snz_hour_bin);
    snz_min_calc  = bin_to_bcd(snz_min_bin);
  end

  assign snooze_hit = sec_tick & armed & snooze_pending & (time_sec == 8'h00) &
                      (time_hour == snooze_hour) & (time_min == snooze_min);
  assign trigger    = alarm_hit | snooze_hit;
`else
  assign trigger    = alarm_hit;
`endif

  always_comb begin
    state_nx      = state;
    alarm_hour_nx = alarm_hour;
    alarm_min_nx  = alarm_min;
    armed_nx      = armed;
    buzz_nx       = buzz_req;
    beep_cnt_nx   = beep_cnt;
    ring_cnt_nx   = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snooze_pending_nx = snooze_pending;
    snooze_hour_nx    = snooze_hour;
    snooze_min_nx     = snooze_min;
`endif
    case (state)
      IDLE: begin
        if (key_set) begin
          state_nx = EDIT_H;
`ifdef ALARM_SNOOZE_EN
          snooze_pending_nx = 1'b0;
`endif
        end else if (trigger) begin
          state_nx    = RINGING;
          buzz_nx     = 1'b1;
          beep_cnt_nx = BEEP_LAST;
          ring_cnt_nx = 8'd0;
`ifdef ALARM_SNOOZE_EN
          if (snooze_hit) snooze_pending_nx = 1'b0;
`endif
        end else if (key_ack && !key_inc) begin
          armed_nx = ~armed;
`ifdef ALARM_SNOOZE_EN
          if (armed) snooze_pending_nx = 1'b0;
`endif
        end
      end
      EDIT_H: begin
        if (key_set)      state_nx = EDIT_M;
        else if (key_inc) alarm_hour_nx = bcd_inc(alarm_hour, 8'h23);
      end
      EDIT_M: begin
        if (key_set) begin
          state_nx = IDLE;
          armed_nx = 1'b1;
        end else if (key_inc) begin
          alarm_min_nx = bcd_inc(alarm_min, 8'h59);
        end
      end
      RINGING: begin
        if (key_ack || (sec_tick && ring_cnt == RING_LAST)) begin
          state_nx    = IDLE;
          buzz_nx     = 1'b0;
          beep_cnt_nx = '0;
          ring_cnt_nx = 8'd0;
`ifdef ALARM_SNOOZE_EN
          if (key_ack) begin
            snooze_pending_nx = 1'b1;
            snooze_hour_nx    = snz_hour_calc;
            snooze_min_nx     = snz_min_calc;
          end
`endif
        end else begin
          if (sec_tick) ring_cnt_nx = ring_cnt + 8'd1;
          if (beep_cnt == '0) begin
            buzz_nx     = ~buzz_req;
            beep_cnt_nx = BEEP_LAST;
          end else begin
            beep_cnt_nx = beep_cnt - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_sec   <= 8'h00;
      alarm_hour <= 8'h00;
      alarm_min  <= 8'h00;
      armed      <= 1'b0;
      buzz_req   <= 1'b0;
      beep_cnt   <= '0;
      ring_cnt   <= 8'd0;
      edit_field <= 2'b00;
      ringing    <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_sec   <= time_sec;
      alarm_hour <= alarm_hour_nx;
      alarm_min  <= alarm_min_nx;
      armed      <= armed_nx;
      buzz_req   <= buzz_nx;
      beep_cnt   <= beep_cnt_nx;
      ring_cnt   <= ring_cnt_nx;
      edit_field <= (state_nx == EDIT_H) ? 2'b01 : (state_nx == EDIT_M) ? 2'b10 : 2'b00;
      ringing    <= (state_nx == RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snooze_pending <= 1'b0;
      snooze_hour    <= 8'h00;
      snooze_min     <= 8'h00;
    end else begin
      snooze_pending <= snooze_pending_nx;
      snooze_hour    <= snooze_hour_nx;
      snooze_min     <= snooze_min_nx;
    end
  end
`endif

endmodule
